// File: rtl/gate_assert_pipe.sv
// Valid-qualified data/predicate pipeline with per-bit gated outputs and violation audit.
// Latency STAGES cycles; optional assertion when GATE_ASSERT_PIPE_CHECK_EN is defined.
// No backpressure: accepts one beat per cycle, bubbles propagate, payload holds on bubbles.

// Single-bit output gate buffer; a plain pass-through in this library.
// Latency 0 (combinational).
// No backpressure.
module br_gate_buf (
  input  logic in,
  output logic out
);
  assign out = in;
endmodule

// Top: STAGES-deep pipeline, per-bit br_gate_buf on the data lane, saturating violation counter.
// Latency STAGES cycles from input_valid to output_valid; viol is combinational from the last stage.
// No backpressure or stall; GATE_ASSERT_PIPE_CHECK_EN adds the should_be_one assertion.
module gate_assert_pipe #(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_valid,
  input  logic                 pred,
  input  logic [WIDTH-1:0]     x,
  input  logic                 clear,
  output logic                 output_valid,
  output logic [WIDTH-1:0]     out,
  output logic                 viol,
  output logic                 viol_sticky,
  output logic [CNT_WIDTH-1:0] viol_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] pred_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  // Valid always advances; payload only loads behind a valid beat so out holds on bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      pred_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= input_valid;
      if (input_valid) begin
        pred_q[0] <= pred;
        data_q[0] <= x;
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          pred_q[k] <= pred_q[k-1];
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign output_valid = valid_q[STAGES-1];
  assign viol         = valid_q[STAGES-1] & ~pred_q[STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_gate
    br_gate_buf u_gate (
      .in  (data_q[STAGES-1][i]),
      .out (out[i])
    );
  end

  // Clear wins over accumulation but still records a same-cycle violation as the first count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_count  <= '0;
      viol_sticky <= 1'b0;
    end else if (clear) begin
      viol_count  <= viol ? CNT_ONE : '0;
      viol_sticky <= viol;
    end else if (viol) begin
      viol_sticky <= 1'b1;
      if (viol_count != CNT_MAX) begin
        viol_count <= viol_count + CNT_ONE;
      end
    end
  end

`ifdef GATE_ASSERT_PIPE_CHECK_EN
  should_be_one: assert property (@(posedge clk) (~viol | rst));
`endif

endmodule

// File: doc/gate_assert_pipe.md
# gate_assert_pipe

Parametrised pipeline that carries a WIDTH-bit data lane and a 1-bit predicate through STAGES valid-qualified register stages. It drives the output data through per-bit br_gate_buf instances, and checks at the output that the predicate holds for every valid beat. It sits where generated pipelines need gated outputs plus an auditable record of predicate violations. It extends the single-bit, fixed two-stage gated-assert pipeline with configurable depth and width, a saturating violation counter, a sticky flag, and software clear.

## Interface
- WIDTH, 8, data lane width in bits; must be at least 1.
- STAGES, 2, number of register stages, which is also the latency; must be at least 1.
- CNT_WIDTH, 8, violation counter width; must be at least 1.
- clk  input  1  clock; every register is updated on its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears every register.
- input_valid  input  1  marks a valid beat on pred and x.
- pred  input  1  predicate that must be 1 for every valid beat.
- x  input  WIDTH  data for the beat.
- clear  input  1  synchronous clear of the violation counter and sticky flag.
- output_valid  output  1  input_valid delayed by STAGES cycles.
- out  output  WIDTH  final-stage data passed through br_gate_buf, one instance per bit.
- viol  output  1  combinational: output_valid & ~final-stage pred.
- viol_sticky  output  1  set by any violation; cleared only by clear or rst.
- viol_count  output  CNT_WIDTH  saturating count of violations.

## Operation
- Each stage k (0..STAGES-1) holds three registers: valid_k, pred_k and data_k. Stage 0 is fed from the inputs; stage k is fed from stage k-1.
- valid_k always loads from the upstream valid, so bubbles propagate.
- pred_k and data_k load only when the upstream valid is 1; otherwise they hold their value.
- out = gate_buf(data_{STAGES-1}). out is a don't-care while output_valid is 0, but it must equal the held register value.
- viol = valid_{STAGES-1} & ~pred_{STAGES-1}.
- Counter and sticky flag, updated on each rising edge after reset is released:
  - clear=1, viol=0: count becomes 0, sticky becomes 0.
  - clear=1, viol=1: count becomes 1, sticky becomes 1. Clear wins, but the same-cycle violation is still recorded.
  - clear=0, viol=1: count becomes min(count+1, 2^CNT_WIDTH-1), and sticky becomes 1. At saturation the count holds at all-ones; it does not wrap.
  - Otherwise both hold.
- Asserting rst at any time, including mid-stream, immediately zeroes every valid, pred, data, count and sticky register. All in-flight beats are dropped; no violation is recorded for them.

## Timing
- Latency: a beat presented at cycle t appears on output_valid/out at cycle t+STAGES.
- Throughput is one beat per cycle. There is no backpressure and no stall input.
- viol is combinational from the final-stage registers.
- viol_sticky and viol_count reflect a violation one cycle after viol is high.
- Reset values: output_valid=0, out=0, viol=0, viol_sticky=0, viol_count=0.
- After rst deasserts, the first beat accepted at cycle t0 emerges at t0+STAGES.

## Configuration
- Macro GATE_ASSERT_PIPE_CHECK_EN.
- When defined: the block instantiates a BR_ASSERT-family concurrent assertion named should_be_one on (~viol | rst), so simulation fails at the first violation.
- When undefined: no assertion is emitted. viol, viol_sticky and viol_count behave identically in both builds.
- Benches that inject violations deliberately build without the macro.

## Test plan
- Latency and bubbles: WIDTH=8, STAGES=3, with pred=1 throughout. Drive x=0x11,0x22 on consecutive valid cycles, one invalid cycle, then x=0x33.
  - Required: output_valid at cycles t+3, t+4 and t+6, with out=0x11, 0x22, 0x33.
  - Required: out holds 0x22 at cycle t+5.
- Violation count: inject three valid beats with pred=0 among passing beats.
  - Required: viol pulses exactly three times, viol_count=3 and viol_sticky=1.
  - Required: invalid beats with pred=0 do not count.
- Saturation: CNT_WIDTH=2, five violations.
  - Required: viol_count reads 1,2,3,3,3 and never wraps to 0.
- Clear priority: assert clear in the same cycle as a violation, with count=2 before.
  - Required: count=1 and sticky=1 on the next cycle.
  - Required: clear alone gives count=0 and sticky=0.
- Reset mid-stream: assert rst asynchronously, between clock edges, while three beats are in flight, one of them with pred=0.
  - Required: all outputs drop to 0 immediately.
  - Required: after release, no stale beat emerges and viol_count stays 0.
- Assertion build: with GATE_ASSERT_PIPE_CHECK_EN defined, a single pred=0 beat makes the assertion fire at its output cycle. With the macro undefined, the same stimulus passes and viol_count=1.
